// File: rtl/uart_pkg.sv
// Shared constants and TX handshake state encoding
// for the UART link controller.
package uart_pkg;

  localparam int RX_DT_W        = 10;
  localparam int RX_DT_PERR_BIT = 8;
  localparam int RX_DT_FERR_BIT = 9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_BUSY = 2'd2
  } tx_state_e;

endpackage

// File: rtl/vs_sync_fifo.sv
// Synchronous FIFO: registered write, show-ahead read,
// full/empty/level flags, synchronous active-low reset.
module vs_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_dout  = r_mem[r_rptr];

  // A push into a full FIFO is allowed when a pop frees a slot
  assign w_wr = i_push && (!o_full || i_pop);
  assign w_rd = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      if (w_wr && !w_rd)      r_level <= r_level + LW'(1);
      else if (!w_wr && w_rd) r_level <= r_level - LW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/uart_link_ctrl.sv
// UART echo path: classify received frames, buffer good
// bytes, hand them back to the transmitter one at a time.
module uart_link_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     RX_DATA_EN,
  input  logic [RX_DT_W-1:0]       RX_DATA_T,
  input  logic                     TX_RDY_R,
  output logic                     TX_RDY_T,
  output logic [7:0]               TX_DATA_R,
  input  logic                     CLR_CNT,
  output logic [$clog2(DEPTH):0]   FIFO_LEVEL,
  output logic [CNT_W-1:0]         PERR_CNT,
  output logic [CNT_W-1:0]         FERR_CNT,
  output logic [CNT_W-1:0]         OVF_CNT
);

  localparam logic [CNT_W-1:0] CMAX = '1;

  tx_state_e        r_state;
  tx_state_e        w_nstate;
  logic             r_rdy_t;
  logic             w_nrdy_t;
  logic [7:0]       r_data;
  logic [7:0]       w_ndata;
  logic             w_pop;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic [7:0]       w_head;
  logic             w_ferr;
  logic             w_perr;
  logic             w_ovf;
  logic [CNT_W-1:0] r_perr;
  logic [CNT_W-1:0] r_ferr;
  logic [CNT_W-1:0] r_ovf;

  // Frame error outranks parity error
  assign w_ferr = RX_DATA_EN && RX_DATA_T[RX_DT_FERR_BIT];
  assign w_perr = RX_DATA_EN && !RX_DATA_T[RX_DT_FERR_BIT]
                  && RX_DATA_T[RX_DT_PERR_BIT];
  assign w_push = RX_DATA_EN && !RX_DATA_T[RX_DT_FERR_BIT]
                  && !RX_DATA_T[RX_DT_PERR_BIT]
                  && (!w_full || w_pop);
  assign w_ovf  = RX_DATA_EN && !RX_DATA_T[RX_DT_FERR_BIT]
                  && !RX_DATA_T[RX_DT_PERR_BIT]
                  && w_full && !w_pop;

  vs_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_push  (w_push),
    .i_din   (RX_DATA_T[7:0]),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (FIFO_LEVEL)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_rdy_t <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      r_state <= w_nstate;
      r_rdy_t <= w_nrdy_t;
      r_data  <= w_ndata;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_nrdy_t = r_rdy_t;
    w_ndata  = r_data;
    w_pop    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty && TX_RDY_R) begin
          w_pop    = 1'b1;
          w_ndata  = w_head;
          w_nrdy_t = 1'b1;
          w_nstate = S_REQ;
        end
      end
      S_REQ: begin
        if (!TX_RDY_R) begin
          w_nrdy_t = 1'b0;
          w_nstate = S_BUSY;
        end
      end
      S_BUSY: begin
        if (TX_RDY_R) w_nstate = S_IDLE;
      end
      default: begin
        w_nrdy_t = 1'b0;
        w_nstate = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST || CLR_CNT) begin
      r_perr <= '0;
      r_ferr <= '0;
      r_ovf  <= '0;
    end else begin
      if (w_perr && r_perr != CMAX) r_perr <= r_perr + CNT_W'(1);
      if (w_ferr && r_ferr != CMAX) r_ferr <= r_ferr + CNT_W'(1);
      if (w_ovf && r_ovf != CMAX)   r_ovf  <= r_ovf + CNT_W'(1);
    end
  end

  assign TX_RDY_T  = r_rdy_t;
  assign TX_DATA_R = r_data;
  assign PERR_CNT  = r_perr;
  assign FERR_CNT  = r_ferr;
  assign OVF_CNT   = r_ovf;

endmodule
